alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Upstream command stage for the ALU: queues byte-wide ALU commands in a small FIFO and issues them
//  one at a time on the ALU control/operand pins. Each command is run for two enabled cycles, so that
//  alu_out and alu_irq reflect this command's operands. The result and irq are then captured and
//  returned on a valid/ready response port. The block sits between the command master and the ALU.
// PARAMETERS
//  DEPTH    4   command FIFO entries (power of 2, >=2)
//  CNT_W    3   width of fifo_count (= log2(DEPTH)+1)
// PORTS
//  alu_clk       in   1      clock, all state on rising edge
//  rst_n         in   1      asynchronous active-low reset
//  cmd_valid     in   1      command offered
//  cmd_ready     out  1      command accepted when cmd_valid&&cmd_ready at edge
//  cmd_bank      in   1      0 = op bank A, 1 = op bank B
//  cmd_op        in   2      opcode within bank
//  cmd_a         in   8      operand A
//  cmd_b         in   8      operand B
//  cmd_irq_clr   in   1      drive alu_irq_clr during this command's result cycle
//  flush         in   1      sync: empty FIFO, abort in-flight command
//  rsp_valid     out  1      response available
//  rsp_ready     in   1      response consumed when rsp_valid&&rsp_ready at edge
//  rsp_data      out  8      captured alu_out
//  rsp_irq       out  1      captured alu_irq
//  busy          out  1      FSM not IDLE or FIFO non-empty
//  fifo_count    out  CNT_W  queued entries, 0..DEPTH
//  alu_enable, alu_enable_a, alu_enable_b   out 1 each   ALU enables
//  alu_op_a, alu_op_b   out 2 each   ALU opcodes
//  alu_in_a, alu_in_b   out 8 each   ALU operands
//  alu_irq_clr   out  1      ALU irq clear
//  alu_out       in   8      ALU result
//  alu_irq       in   1      ALU interrupt
// BEHAVIOUR
//  Reset: FSM=IDLE, FIFO empty, every output 0 (fifo_count=0, rsp_*=0, all alu_* drives=0).
//  The reset value of cmd_ready is 1, because the FIFO is empty.
//  cmd_ready = !full && !flush. It does not depend on a same-cycle pop. A push when empty is popped
//  no earlier than the next edge.
//  FSM, one state per cycle unless noted. cur = the popped command register:
//   IDLE:    FIFO non-empty -> pop head into cur, go to ISSUE. Otherwise stay.
//   ISSUE:   alu_enable=1, enable_a=!bank, enable_b=bank, op_a=op_b=cur.op, in_a/in_b=cur operands,
//            alu_irq_clr=0 -> PUSH.
//   PUSH:    same drives as ISSUE, with alu_irq_clr=cur.irq_clr -> CAPTURE.
//   CAPTURE: all enables 0. At the edge, rsp_data<=alu_out, rsp_irq<=alu_irq, rsp_valid<=1 -> RSP.
//   RSP:     hold rsp_* until rsp_ready. On the handshake edge, rsp_valid<=0, then go to ISSUE
//            (popping the head) if the FIFO is non-empty, else to IDLE.
//  Outside ISSUE/PUSH, alu_enable=enable_a=enable_b=alu_irq_clr=0. alu_op_*/alu_in_* hold their last values.
//  Latency: with an empty FIFO and IDLE, a command accepted at edge k gives rsp_valid=1 after edge k+4.
//  Throughput: one command per 4 cycles when rsp_ready is held high.
//  Simultaneous push and pop: count is unchanged, and pointers wrap modulo DEPTH.
//  Full: count==DEPTH, cmd_ready=0, and the offered command is held by the master, not dropped.
//  flush (highest priority): at the edge, the FIFO is emptied, FSM->IDLE and rsp_valid<=0. A
//  same-cycle cmd_valid is not accepted, and the ALU enables drop the following cycle.
//  Async reset mid-command: immediate return to reset values. No partial response is emitted.
// TESTING
//  1 Bank A op 00, a=FF, b=FF, irq_clr=0, rsp_ready=1 -> 4 cycles later, rsp_data=FF, rsp_irq=1.
//  2 Bank B op 11, a=F0, b=0F -> rsp_data=FF, rsp_irq=1. Bank A op 11, a=55, b=AA -> rsp_data=FF, rsp_irq=0.
//  3 rsp_ready=0, 6 back-to-back commands -> 5 accepted, cmd_ready=0 with fifo_count=4. Release
//    rsp_ready -> responses appear in order, and the 6th command is then accepted.
//  4 Hold rsp_ready=0 for 3 cycles after rsp_valid -> rsp_data/rsp_irq stable. The next command is
//    not issued (alu_enable=0) until the handshake.
//  5 Assert flush during PUSH with 2 queued -> next cycle FSM IDLE, fifo_count=0, rsp_valid=0 and
//    stays 0, busy=0.
//  6 Deassert rst_n async mid-ISSUE -> outputs zero without a clock edge. After release, a new
//    command completes with the correct rsp_data.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO and issue sequencer in front of the ALU: pops queued byte-wide commands, runs each
// for two enabled cycles, then captures alu_out/alu_irq onto a valid/ready response port.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             alu_clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_bank,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic             cmd_irq_clr,
  input  logic             flush,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_irq,
  output logic             busy,
  output logic [CNT_W-1:0] fifo_count,
  output logic             alu_enable,
  output logic             alu_enable_a,
  output logic             alu_enable_b,
  output logic [1:0]       alu_op_a,
  output logic [1:0]       alu_op_b,
  output logic [7:0]       alu_in_a,
  output logic [7:0]       alu_in_b,
  output logic             alu_irq_clr,
  input  logic [7:0]       alu_out,
  input  logic             alu_irq
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic       bank;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       irq_clr;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_PUSH,
    S_CAPTURE,
    S_RSP
  } state_t;

  state_t           state, state_nxt;
  cmd_t             mem [DEPTH];
  cmd_t             cur;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, empty, push, pop;

  assign full  = (fifo_count == CNT_W'(DEPTH));
  assign empty = (fifo_count == '0);

  // Ready is deliberately blind to a same-cycle pop, so a full FIFO stalls one extra cycle.
  assign cmd_ready = !full && !flush;
  assign push      = cmd_valid && cmd_ready;
  assign busy      = (state != S_IDLE) || !empty;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE:   state_nxt = S_PUSH;
      S_PUSH:    state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_RSP;
      S_RSP: begin
        if (rsp_ready) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = S_ISSUE;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (flush) begin
      pop       = 1'b0;
      state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cur   <= '0;
    end else begin
      state <= state_nxt;
      if (pop) cur <= mem[rd_ptr];
    end
  end

  always_ff @(posedge alu_clk) begin
    if (push) mem[wr_ptr] <= '{bank: cmd_bank, op: cmd_op, a: cmd_a, b: cmd_b, irq_clr: cmd_irq_clr};
  end

  always_ff @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_irq   <= 1'b0;
    end else if (flush) begin
      rsp_valid <= 1'b0;
    end else if (state == S_CAPTURE) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_out;
      rsp_irq   <= alu_irq;
    end else if (state == S_RSP && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Opcode/operand pins follow cur, which only changes on a pop, so they hold between commands.
  assign alu_enable   = (state == S_ISSUE) || (state == S_PUSH);
  assign alu_enable_a = alu_enable && !cur.bank;
  assign alu_enable_b = alu_enable && cur.bank;
  assign alu_op_a     = cur.op;
  assign alu_op_b     = cur.op;
  assign alu_in_a     = cur.a;
  assign alu_in_b     = cur.b;
  assign alu_irq_clr  = (state == S_PUSH) && cur.irq_clr;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small behavioural ALU hanging off the alu_* pins.
module tb_alu_cmd_sequencer;

  logic       alu_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_bank = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [7:0] cmd_a = '0;
  logic [7:0] cmd_b = '0;
  logic       cmd_irq_clr = 1'b0;
  logic       flush = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_irq;
  logic       busy;
  logic [2:0] fifo_count;
  logic       alu_enable, alu_enable_a, alu_enable_b;
  logic [1:0] alu_op_a, alu_op_b;
  logic [7:0] alu_in_a, alu_in_b;
  logic       alu_irq_clr;
  logic [7:0] alu_out;
  logic       alu_irq;

  int total = 0;
  int bad = 0;

  always #5 alu_clk = ~alu_clk;

  alu_cmd_sequencer #(.DEPTH(4), .CNT_W(3)) dut (
    .alu_clk(alu_clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_bank(cmd_bank), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_irq_clr(cmd_irq_clr), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_irq(rsp_irq),
    .busy(busy), .fifo_count(fifo_count),
    .alu_enable(alu_enable), .alu_enable_a(alu_enable_a), .alu_enable_b(alu_enable_b),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .alu_irq_clr(alu_irq_clr), .alu_out(alu_out), .alu_irq(alu_irq)
  );

  // Bench ALU. Bank A: AND, OR, XOR, OR-with-zero-flag. Bank B: ADD, SUB, XNOR, XOR.
  // irq is the all-ones flag (zero flag for bank A op 3), forced low by alu_irq_clr.
  function automatic logic [8:0] alu_f(input logic bank, input logic [1:0] op,
                                       input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic       f;
    if (!bank) begin
      case (op)
        2'd0:    r = a & b;
        2'd1:    r = a | b;
        2'd2:    r = a ^ b;
        default: r = a | b;
      endcase
      f = (op == 2'd3) ? (r == 8'h00) : (r == 8'hFF);
    end else begin
      case (op)
        2'd0:    r = a + b;
        2'd1:    r = a - b;
        2'd2:    r = ~(a ^ b);
        default: r = a ^ b;
      endcase
      f = (r == 8'hFF);
    end
    return {f, r};
  endfunction

  always_ff @(posedge alu_clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out <= '0;
      alu_irq <= 1'b0;
    end else if (alu_enable_a) begin
      alu_out <= alu_f(1'b0, alu_op_a, alu_in_a, alu_in_b) & 9'h0FF;
      alu_irq <= alu_f(1'b0, alu_op_a, alu_in_a, alu_in_b) >> 8 != 0 && !alu_irq_clr;
    end else if (alu_enable_b) begin
      alu_out <= alu_f(1'b1, alu_op_b, alu_in_a, alu_in_b) & 9'h0FF;
      alu_irq <= alu_f(1'b1, alu_op_b, alu_in_a, alu_in_b) >> 8 != 0 && !alu_irq_clr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer a command at a falling edge; returns at the falling edge after it is accepted.
  task automatic push_cmd(input logic bank, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic clr);
    bit done;
    done = 1'b0;
    cmd_valid = 1'b1; cmd_bank = bank; cmd_op = op; cmd_a = a; cmd_b = b; cmd_irq_clr = clr;
    for (int i = 0; i < 40 && !done; i++) begin
      if (cmd_ready) done = 1'b1;
      @(negedge alu_clk);
    end
    cmd_valid = 1'b0;
    chk("push_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 40 && !rsp_valid; i++) @(negedge alu_clk);
    chk("rsp_timeout", 32'(rsp_valid), 32'd1);
  endtask

  initial begin
    int   got;
    bit   pend;
    // reset state
    #3;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_en", 32'({alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr}), 32'd0);
    chk("rst_alu_drv", 32'({alu_op_a, alu_op_b, alu_in_a, alu_in_b}), 32'd0);
    @(negedge alu_clk);
    @(negedge alu_clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge alu_clk);

    // 1: latency and first result
    push_cmd(1'b0, 2'd0, 8'hFF, 8'hFF, 1'b0);
    chk("t1_count1", 32'(fifo_count), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    @(negedge alu_clk);
    chk("t1_issue_en", 32'({alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr}), 32'b1100);
    chk("t1_issue_drv", 32'({alu_op_a, alu_op_b, alu_in_a, alu_in_b}), 32'h0FFFF);
    chk("t1_count0", 32'(fifo_count), 32'd0);
    @(negedge alu_clk);
    chk("t1_push_en", 32'(alu_enable), 32'd1);
    @(negedge alu_clk);
    chk("t1_capture_en", 32'(alu_enable), 32'd0);
    chk("t1_not_yet", 32'(rsp_valid), 32'd0);
    @(negedge alu_clk);
    chk("t1_valid", 32'(rsp_valid), 32'd1);
    chk("t1_data", 32'(rsp_data), 32'hFF);
    chk("t1_irq", 32'(rsp_irq), 32'd1);
    @(negedge alu_clk);
    chk("t1_done_valid", 32'(rsp_valid), 32'd0);
    chk("t1_done_busy", 32'(busy), 32'd0);

    // 2: bank B and other opcodes, irq_clr
    push_cmd(1'b1, 2'd3, 8'hF0, 8'h0F, 1'b0);
    wait_rsp();
    chk("t2a_data", 32'(rsp_data), 32'hFF);
    chk("t2a_irq", 32'(rsp_irq), 32'd1);
    @(negedge alu_clk);
    push_cmd(1'b0, 2'd3, 8'h55, 8'hAA, 1'b0);
    wait_rsp();
    chk("t2b_data", 32'(rsp_data), 32'hFF);
    chk("t2b_irq", 32'(rsp_irq), 32'd0);
    @(negedge alu_clk);
    push_cmd(1'b0, 2'd0, 8'hFF, 8'hFF, 1'b1);
    wait_rsp();
    chk("t2c_data", 32'(rsp_data), 32'hFF);
    chk("t2c_irqclr", 32'(rsp_irq), 32'd0);
    @(negedge alu_clk);

    // 3: fill while responses are stalled
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(1'b0, 2'd2, 8'(i), 8'h10, 1'b0);
    cmd_valid = 1'b1; cmd_bank = 1'b0; cmd_op = 2'd2; cmd_a = 8'd5; cmd_b = 8'h10;
    repeat (3) @(negedge alu_clk);
    chk("t3_full_ready", 32'(cmd_ready), 32'd0);
    chk("t3_full_count", 32'(fifo_count), 32'd4);
    rsp_ready = 1'b1;
    got = 0;
    pend = 1'b0;
    for (int i = 0; i < 80 && got < 6; i++) begin
      if (pend) begin cmd_valid = 1'b0; pend = 1'b0; end
      if (cmd_valid && cmd_ready) pend = 1'b1;
      if (rsp_valid) begin
        chk($sformatf("t3_data%0d", got), 32'(rsp_data), 32'h10 + 32'(got));
        got++;
      end
      @(negedge alu_clk);
    end
    cmd_valid = 1'b0;
    chk("t3_rsp_count", 32'(got), 32'd6);
    chk("t3_idle", 32'(busy), 32'd0);

    // 4: response held under backpressure
    rsp_ready = 1'b0;
    push_cmd(1'b0, 2'd1, 8'h0F, 8'hF0, 1'b0);
    push_cmd(1'b1, 2'd0, 8'h01, 8'h02, 1'b0);
    wait_rsp();
    chk("t4_data", 32'(rsp_data), 32'hFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge alu_clk);
      chk("t4_hold", 32'({rsp_valid, rsp_irq, rsp_data}), 32'h3FF);
      chk("t4_no_issue", 32'(alu_enable), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge alu_clk);
    chk("t4_next_issue", 32'({alu_enable, alu_enable_a, alu_enable_b}), 32'b101);
    chk("t4_valid_drop", 32'(rsp_valid), 32'd0);
    wait_rsp();
    chk("t4_data2", 32'({rsp_irq, rsp_data}), 32'h003);
    @(negedge alu_clk);

    // 5: flush during PUSH with two queued
    push_cmd(1'b0, 2'd0, 8'h11, 8'h22, 1'b1);
    push_cmd(1'b0, 2'd0, 8'h33, 8'h44, 1'b0);
    push_cmd(1'b0, 2'd0, 8'h55, 8'h66, 1'b0);
    chk("t5_push_state", 32'({alu_enable, alu_irq_clr}), 32'b11);
    chk("t5_queued", 32'(fifo_count), 32'd2);
    flush = 1'b1;
    cmd_valid = 1'b1;
    #1;
    chk("t5_flush_ready", 32'(cmd_ready), 32'd0);
    @(negedge alu_clk);
    flush = 1'b0;
    cmd_valid = 1'b0;
    chk("t5_count", 32'(fifo_count), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_en", 32'(alu_enable), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t5_no_rsp", 32'({rsp_valid, busy}), 32'd0);
      @(negedge alu_clk);
    end

    // 6: async reset in ISSUE
    push_cmd(1'b0, 2'd2, 8'h3C, 8'hC3, 1'b0);
    @(negedge alu_clk);
    chk("t6_issue", 32'(alu_enable), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_en", 32'({alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr}), 32'd0);
    chk("t6_rst_drv", 32'({alu_in_a, alu_in_b, alu_op_a}), 32'd0);
    chk("t6_rst_state", 32'({busy, rsp_valid, fifo_count, cmd_ready}), 32'd1);
    @(negedge alu_clk);
    rst_n = 1'b1;
    @(negedge alu_clk);
    chk("t6_no_partial", 32'(rsp_valid), 32'd0);
    push_cmd(1'b0, 2'd0, 8'hF0, 8'h3C, 1'b0);
    wait_rsp();
    chk("t6_data", 32'({rsp_irq, rsp_data}), 32'h030);
    @(negedge alu_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
